blink_ctrl: RTL and testbench
=============================

BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clock cycles per tail-light step; legal values 2..255.
REQ-002 SHALL have parameter SEQ_LEN, default 4: steps per full tail-light sequence (off plus three lamps); legal values 2..15.
REQ-003 SHALL have parameter TAP_SEQS, default 3: sequences run for a lane-change tap; legal values 1..15.
REQ-004 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port left_req, input, 1: left lever held (level).
REQ-007 SHALL have port right_req, input, 1: right lever held (level).
REQ-008 SHALL have port left_tap, input, 1: one-cycle lane-change tap, left.
REQ-009 SHALL have port right_tap, input, 1: one-cycle lane-change tap, right.
REQ-010 SHALL have port haz_btn, input, 1: hazard button; each rising edge toggles hazard.
REQ-011 SHALL have port l, output, 1: left command to the tail-light FSM.
REQ-012 SHALL have port r, output, 1: right command to the tail-light FSM.
REQ-013 SHALL have port step, output, 1: one-cycle advance enable to the tail-light FSM.
REQ-014 SHALL have port mode, output, 2: current mode; 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ.
REQ-015 SHALL have port busy, output, 1: high whenever mode is not IDLE.

Function
REQ-016 SHALL implement states IDLE, LEFT, RIGHT and HAZ.
REQ-017 SHALL register all outputs.
REQ-018 SHALL decode l as 1 in LEFT or HAZ, and r as 1 in RIGHT or HAZ.
REQ-019 SHALL register haz_btn and detect its rising edge; each edge toggles the haz_on flag.
REQ-020 SHALL arbitrate as: haz_on > single lever (left_req xor right_req) > pending tap > IDLE.
REQ-021 SHALL treat both levers high together as no lever request.
REQ-022 SHALL hold the prescaler div_cnt at 0 in IDLE; in other states div_cnt counts 0..TICK_DIV-1 and wraps.
REQ-023 SHALL assert step in the cycle after div_cnt equals TICK_DIV-1, so step pulses once every TICK_DIV cycles.
REQ-024 SHALL hold step_cnt at 0 in IDLE; in other states step_cnt counts 0..SEQ_LEN-1 on each step and wraps.
REQ-025 SHALL define boundary as a step with step_cnt equal to SEQ_LEN-1.
REQ-026 SHALL, in IDLE, enter the arbitration winner on the next clock edge with div_cnt and step_cnt at 0; the first step follows TICK_DIV cycles after entry.
REQ-027 SHALL, in LEFT or RIGHT, re-arbitrate only at a boundary, so a lever change mid-sequence takes effect after the current sequence completes.
REQ-028 SHALL move LEFT/RIGHT/IDLE to HAZ on the cycle after haz_on becomes 1, and clear div_cnt and step_cnt.
REQ-029 SHALL move HAZ to IDLE on the cycle after haz_on clears, and clear div_cnt and step_cnt.
REQ-030 SHALL load tap_cnt with TAP_SEQS on a tap and latch its direction.
REQ-031 SHALL decrement tap_cnt at each boundary.
REQ-032 SHALL go to IDLE (no lever held) when tap_cnt is 1 at a boundary.
REQ-033 SHALL let a held lever override a tap, and SHALL clear tap_cnt when the lever wins.
REQ-034 SHALL ignore a tap in HAZ.
REQ-035 SHALL, when a tap arrives while running, reload tap_cnt and take the new direction at the next boundary.
REQ-036 SHALL, when left_tap and right_tap are high in the same cycle, ignore both.

Reset
REQ-037 SHALL, while reset is high, immediately clear state to IDLE, clear haz_on, div_cnt, step_cnt and tap_cnt, and drive l=r=step=busy=0 and mode=00.
REQ-038 SHALL clear the registered haz_btn to 0 on reset, so a button held through reset release toggles hazard on the first cycle after release.
REQ-039 SHALL assert reset asynchronously and release it synchronously to clk.

Verification (TICK_DIV=4, SEQ_LEN=4, TAP_SEQS=3)
REQ-040 SHALL cover reset: reset high, all inputs 1 -> mode=00, l=r=step=busy=0 with no clock edge needed.
REQ-041 SHALL cover a held lever: left_req held from cycle 0 -> mode=01, l=1, r=0 from cycle 1; step high at cycles 5, 9, 13, ...
REQ-042 SHALL cover a tap: left_tap pulse at cycle 0 -> LEFT for exactly 3 sequences (48 cycles), then mode=00 and busy=0.
REQ-043 SHALL cover a lever change: left_req, then right_req at cycle 7 -> LEFT holds until the boundary at cycle 17, then mode=10.
REQ-044 SHALL cover hazard: haz_btn edge mid-LEFT -> next cycle mode=11, l=r=1, step counts restart; second edge -> next cycle mode=00.
REQ-045 SHALL cover reset mid-hazard: reset pulse during HAZ -> outputs zero immediately; on release, haz_on=0 and mode=00 with no button activity.

Source files
------------

// File: rtl/blink_ctrl.sv
// Turn-signal / hazard controller: arbitrates levers, lane-change taps and hazard
// into a mode plus l/r commands and a prescaled step pulse for the tail-light FSM.
module blink_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned SEQ_LEN  = 4,
  parameter int unsigned TAP_SEQS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       left_tap,
  input  logic       right_tap,
  input  logic       haz_btn,
  output logic       l,
  output logic       r,
  output logic       step,
  output logic [1:0] mode,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] HAZ   = 2'b11;

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] SEQ_LAST = 4'(SEQ_LEN - 1);
  localparam logic [3:0] TAP_LOAD = 4'(TAP_SEQS);

  logic [1:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] stepc_q, stepc_d;
  logic [3:0] tap_cnt_q, tap_cnt_d;
  logic       tap_dir_q, tap_dir_d;
  logic       haz_btn_q;
  logic       haz_on_q, haz_on_d;
  logic       step_q, step_d;
  logic       l_q, r_q, busy_q;

  logic lever;
  logic tap_fire;
  logic boundary;
  logic clr;

  assign lever    = left_req ^ right_req;
  assign tap_fire = (left_tap ^ right_tap) && (state_q != HAZ);
  assign boundary = step_q && (stepc_q == SEQ_LAST);
  assign haz_on_d = haz_on_q ^ (haz_btn & ~haz_btn_q);

  always_comb begin
    state_d   = state_q;
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 8'd1;
    stepc_d   = step_q ? ((stepc_q == SEQ_LAST) ? '0 : stepc_q + 4'd1) : stepc_q;
    tap_cnt_d = tap_cnt_q;
    tap_dir_d = tap_dir_q;
    clr       = 1'b0;

    if (tap_fire) begin
      tap_cnt_d = TAP_LOAD;
      tap_dir_d = right_tap;
    end

    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (haz_on_q) begin
          state_d = HAZ;
        end else if (lever) begin
          state_d   = left_req ? LEFT : RIGHT;
          tap_cnt_d = '0;
        end else if (tap_fire) begin
          state_d = right_tap ? RIGHT : LEFT;
        end else if (tap_cnt_q != '0) begin
          state_d = tap_dir_q ? RIGHT : LEFT;
        end
      end
      LEFT, RIGHT: begin
        if (haz_on_q) begin
          state_d = HAZ;
          clr     = 1'b1;
        end else if (boundary) begin
          // A fresh tap this cycle reloads the count instead of consuming a sequence.
          if (!tap_fire && tap_cnt_q != '0) tap_cnt_d = tap_cnt_q - 4'd1;
          if (lever) begin
            state_d   = left_req ? LEFT : RIGHT;
            tap_cnt_d = '0;
          end else if (tap_fire) begin
            state_d = right_tap ? RIGHT : LEFT;
          end else if (tap_cnt_q > 4'd1) begin
            state_d = tap_dir_q ? RIGHT : LEFT;
          end else begin
            state_d = IDLE;
            clr     = 1'b1;
          end
        end
      end
      default: begin
        if (!haz_on_q) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
    endcase

    if (clr) begin
      div_d   = '0;
      stepc_d = '0;
    end
  end

  assign step_d = !clr && (state_q != IDLE) && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      stepc_q   <= '0;
      tap_cnt_q <= '0;
      tap_dir_q <= 1'b0;
      haz_btn_q <= 1'b0;
      haz_on_q  <= 1'b0;
      step_q    <= 1'b0;
      l_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      stepc_q   <= stepc_d;
      tap_cnt_q <= tap_cnt_d;
      tap_dir_q <= tap_dir_d;
      haz_btn_q <= haz_btn;
      haz_on_q  <= haz_on_d;
      step_q    <= step_d;
      l_q       <= (state_d == LEFT)  || (state_d == HAZ);
      r_q       <= (state_d == RIGHT) || (state_d == HAZ);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign l    = l_q;
  assign r    = r_q;
  assign step = step_q;
  assign mode = state_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl at TICK_DIV=4, SEQ_LEN=4, TAP_SEQS=3.
module tb_blink_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left_req = 1'b0, right_req = 1'b0;
  logic       left_tap = 1'b0, right_tap = 1'b0;
  logic       haz_btn = 1'b0;
  logic       l, r, step, busy;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  blink_ctrl #(.TICK_DIV(4), .SEQ_LEN(4), .TAP_SEQS(3)) dut (
    .clk(clk), .reset(reset),
    .left_req(left_req), .right_req(right_req),
    .left_tap(left_tap), .right_tap(right_tap),
    .haz_btn(haz_btn),
    .l(l), .r(r), .step(step), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected l/r/busy follow from the expected mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ.
  task automatic chk_out(input string tag, input int cyc, input logic [1:0] em, input logic es);
    chk($sformatf("%s.mode@%0d", tag, cyc), 8'(mode), 8'(em));
    chk($sformatf("%s.l@%0d", tag, cyc), 8'(l), 8'(em[0]));
    chk($sformatf("%s.r@%0d", tag, cyc), 8'(r), 8'(em[1]));
    chk($sformatf("%s.busy@%0d", tag, cyc), 8'(busy), 8'(em != 2'b00));
    chk($sformatf("%s.step@%0d", tag, cyc), 8'(step), 8'(es));
  endtask

  initial begin
    logic [1:0] em;
    logic       es;

    // Reset asserted with all inputs high; outputs must clear before any clock edge.
    left_req = 1; right_req = 1; left_tap = 1; right_tap = 1; haz_btn = 1;
    #1 reset = 1;
    #1 chk_out("rst_async", 0, 2'b00, 1'b0);
    tick();
    tick();
    chk_out("rst_held", 0, 2'b00, 1'b0);
    left_req = 0; right_req = 0; left_tap = 0; right_tap = 0; haz_btn = 0;
    reset = 0;
    tick();
    tick();

    // Held left lever, released mid-sequence: LEFT until boundary at 17.
    left_req = 1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      em = (c <= 17) ? 2'b01 : 2'b00;
      es = (c >= 5) && (c <= 17) && ((c - 1) % 4 == 0);
      chk_out("lever", c, em, es);
      if (c == 14) left_req = 0;
    end
    tick();

    // Lever change at cycle 7 takes effect after boundary at 17.
    left_req = 1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      em = (c <= 17) ? 2'b01 : (c <= 33) ? 2'b10 : 2'b00;
      es = (c >= 5) && (c <= 33) && ((c - 1) % 4 == 0);
      chk_out("change", c, em, es);
      if (c == 7) begin left_req = 0; right_req = 1; end
      if (c == 22) right_req = 0;
    end
    tick();

    // Left tap: three full sequences then IDLE.
    left_tap = 1;
    for (int c = 1; c <= 52; c++) begin
      tick();
      left_tap = 0;
      em = (c <= 49) ? 2'b01 : 2'b00;
      es = (c >= 5) && (c <= 49) && ((c - 1) % 4 == 0);
      chk_out("tap", c, em, es);
    end

    // Simultaneous taps are both ignored.
    left_tap = 1; right_tap = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      left_tap = 0; right_tap = 0;
      chk_out("dualtap", c, 2'b00, 1'b0);
    end

    // Hazard edge mid-LEFT, then second edge returns to IDLE.
    left_req = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      em = (c <= 7) ? 2'b01 : (c <= 18) ? 2'b11 : 2'b00;
      es = (c == 5) || (c == 12) || (c == 16);
      chk_out("haz", c, em, es);
      if (c == 6)  haz_btn = 1;
      if (c == 7)  haz_btn = 0;
      if (c == 14) left_req = 0;
      if (c == 17) haz_btn = 1;
      if (c == 18) haz_btn = 0;
    end

    // Reset pulse during hazard clears outputs immediately and drops hazard.
    haz_btn = 1;
    tick();
    haz_btn = 0;
    tick();
    chk_out("haz2", 2, 2'b11, 1'b0);
    tick();
    #2 reset = 1;
    #1 chk_out("rst_mid", 0, 2'b00, 1'b0);
    @(posedge clk);
    #1 reset = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk_out("post_rst", c, 2'b00, 1'b0);
    end

    // Button held through reset release toggles hazard on; a tap in HAZ is ignored.
    reset = 1; haz_btn = 1;
    tick();
    tick();
    reset = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      em = (c >= 2 && c <= 5) ? 2'b11 : 2'b00;
      chk_out("heldbtn", c, em, 1'b0);
      if (c == 2) left_tap = 1;
      if (c == 3) begin left_tap = 0; haz_btn = 0; end
      if (c == 4) haz_btn = 1;
      if (c == 5) haz_btn = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
